// File: rtl/alu_unit.sv
// alu_unit: RV32I ALU with optional iterative RV32M unit.
// Define ALU_MULDIV_EN to build the MUL/DIV states and datapath.
// Ports: clk, rst (async, active-low), rdy (stall when low),
//   alu_rb (rollback), alu_ena/opt/val1/val2/imm/rob_idx (issue),
//   alu_busy (RS stall), cdb_alu_valid/src/val (result broadcast).
package alu_pkg;
  localparam int INST_OPT_W = 6;
  localparam int ROB_IDX_W  = 4;

  localparam logic [INST_OPT_W-1:0] OP_ADD    = 6'h00;
  localparam logic [INST_OPT_W-1:0] OP_SUB    = 6'h01;
  localparam logic [INST_OPT_W-1:0] OP_SLL    = 6'h02;
  localparam logic [INST_OPT_W-1:0] OP_SLT    = 6'h03;
  localparam logic [INST_OPT_W-1:0] OP_SLTU   = 6'h04;
  localparam logic [INST_OPT_W-1:0] OP_XOR    = 6'h05;
  localparam logic [INST_OPT_W-1:0] OP_SRL    = 6'h06;
  localparam logic [INST_OPT_W-1:0] OP_SRA    = 6'h07;
  localparam logic [INST_OPT_W-1:0] OP_OR     = 6'h08;
  localparam logic [INST_OPT_W-1:0] OP_AND    = 6'h09;
  localparam logic [INST_OPT_W-1:0] OP_ADDI   = 6'h0A;
  localparam logic [INST_OPT_W-1:0] OP_SLTI   = 6'h0B;
  localparam logic [INST_OPT_W-1:0] OP_SLTIU  = 6'h0C;
  localparam logic [INST_OPT_W-1:0] OP_XORI   = 6'h0D;
  localparam logic [INST_OPT_W-1:0] OP_ORI    = 6'h0E;
  localparam logic [INST_OPT_W-1:0] OP_ANDI   = 6'h0F;
  localparam logic [INST_OPT_W-1:0] OP_SLLI   = 6'h10;
  localparam logic [INST_OPT_W-1:0] OP_SRLI   = 6'h11;
  localparam logic [INST_OPT_W-1:0] OP_SRAI   = 6'h12;
  localparam logic [INST_OPT_W-1:0] OP_LUI    = 6'h13;
  localparam logic [INST_OPT_W-1:0] OP_AUIPC  = 6'h14;
  localparam logic [INST_OPT_W-1:0] OP_BEQ    = 6'h15;
  localparam logic [INST_OPT_W-1:0] OP_BNE    = 6'h16;
  localparam logic [INST_OPT_W-1:0] OP_BLT    = 6'h17;
  localparam logic [INST_OPT_W-1:0] OP_BGE    = 6'h18;
  localparam logic [INST_OPT_W-1:0] OP_BLTU   = 6'h19;
  localparam logic [INST_OPT_W-1:0] OP_BGEU   = 6'h1A;
  // RV32M block: opcode[5:3] == 3'b100, opcode[2] selects divide
  localparam logic [INST_OPT_W-1:0] OP_MUL    = 6'h20;
  localparam logic [INST_OPT_W-1:0] OP_MULH   = 6'h21;
  localparam logic [INST_OPT_W-1:0] OP_MULHSU = 6'h22;
  localparam logic [INST_OPT_W-1:0] OP_MULHU  = 6'h23;
  localparam logic [INST_OPT_W-1:0] OP_DIV    = 6'h24;
  localparam logic [INST_OPT_W-1:0] OP_DIVU   = 6'h25;
  localparam logic [INST_OPT_W-1:0] OP_REM    = 6'h26;
  localparam logic [INST_OPT_W-1:0] OP_REMU   = 6'h27;
endpackage

module alu_unit
  import alu_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  alu_rb,
  input  logic                  alu_ena,
  input  logic [INST_OPT_W-1:0] alu_opt,
  input  logic [31:0]           alu_val1,
  input  logic [31:0]           alu_val2,
  input  logic [31:0]           alu_imm,
  input  logic [ROB_IDX_W-1:0]  alu_rob_idx,
  output logic                  alu_busy,
  output logic                  cdb_alu_valid,
  output logic [ROB_IDX_W-1:0]  cdb_alu_src,
  output logic [31:0]           cdb_alu_val
);

  if (MUL_STAGES < 1 || MUL_STAGES > 8) begin : g_bad_stages
    $error("alu_unit: MUL_STAGES must be 1..8");
  end

  logic                 use_imm;
  logic [31:0]          op_b;
  logic [4:0]           shamt;
  logic [31:0]          base_res;
  logic                 accept;
  logic                 vld_d, vld_q;
  logic [ROB_IDX_W-1:0] src_d, src_q;
  logic [31:0]          val_d, val_q;

  always_comb begin
    use_imm = 1'b0;
    unique case (alu_opt)
      OP_ADDI, OP_SLTI, OP_SLTIU,
      OP_XORI, OP_ORI, OP_ANDI,
      OP_SLLI, OP_SRLI, OP_SRAI: use_imm = 1'b1;
      default:                   use_imm = 1'b0;
    endcase
  end

  assign op_b  = use_imm ? alu_imm : alu_val2;
  assign shamt = op_b[4:0];

  always_comb begin
    base_res = 32'd0;
    unique case (alu_opt)
      OP_ADD, OP_ADDI:
        base_res = alu_val1 + op_b;
      OP_SUB:
        base_res = alu_val1 - op_b;
      OP_SLL, OP_SLLI:
        base_res = alu_val1 << shamt;
      OP_SLT, OP_SLTI:
        base_res = {31'd0, $signed(alu_val1) < $signed(op_b)};
      OP_SLTU, OP_SLTIU:
        base_res = {31'd0, alu_val1 < op_b};
      OP_XOR, OP_XORI:
        base_res = alu_val1 ^ op_b;
      OP_OR, OP_ORI:
        base_res = alu_val1 | op_b;
      OP_AND, OP_ANDI:
        base_res = alu_val1 & op_b;
      OP_SRL, OP_SRLI:
        base_res = alu_val1 >> shamt;
      OP_SRA, OP_SRAI:
        base_res = $unsigned($signed(alu_val1) >>> shamt);
      OP_LUI:
        base_res = alu_imm;
      OP_AUIPC:
        base_res = alu_val1 + alu_imm;
      OP_BEQ:
        base_res = {31'd0, alu_val1 == alu_val2};
      OP_BNE:
        base_res = {31'd0, alu_val1 != alu_val2};
      OP_BLT:
        base_res = {31'd0, $signed(alu_val1) < $signed(alu_val2)};
      OP_BGE:
        base_res = {31'd0, $signed(alu_val1) >= $signed(alu_val2)};
      OP_BLTU:
        base_res = {31'd0, alu_val1 < alu_val2};
      OP_BGEU:
        base_res = {31'd0, alu_val1 >= alu_val2};
      default:
        base_res = 32'd0;
    endcase
  end

  assign accept = alu_ena & rdy & ~alu_rb & ~alu_busy;

`ifdef ALU_MULDIV_EN
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [4:0] MUL_LAST = 5'(MUL_STAGES - 1);

  logic [1:0]            state_d, state_q;
  logic [4:0]            cnt_d, cnt_q;
  logic [INST_OPT_W-1:0] mop_d, mop_q;
  logic [ROB_IDX_W-1:0]  tag_d, tag_q;
  // opa: sign-extended multiplicand, or quotient shift register
  logic [32:0]           opa_d, opa_q;
  // opb: sign-extended multiplier, or divisor magnitude
  logic [32:0]           opb_d, opb_q;
  logic [31:0]           rem_d, rem_q;
  logic                  negq_d, negq_q;
  logic                  negr_d, negr_q;

  logic        is_m, is_div;
  logic        sgn_a, sgn_b, neg_a, neg_b;
  logic [31:0] abs_a, abs_b;
  logic [63:0] prod;
  logic [32:0] trial;
  logic [31:0] quo_n, rem_n;
  logic [31:0] mul_res, div_res;

  assign is_m   = (alu_opt[5:3] == 3'b100);
  assign is_div = is_m & alu_opt[2];

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (alu_opt)
      OP_MULH, OP_DIV, OP_REM: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      OP_MULHSU: sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign neg_a = sgn_a & alu_val1[31];
  assign neg_b = sgn_b & alu_val2[31];
  assign abs_a = neg_a ? -alu_val1 : alu_val1;
  assign abs_b = neg_b ? -alu_val2 : alu_val2;

  assign prod = 64'($signed(opa_q)) * 64'($signed(opb_q));
  assign mul_res = (mop_q == OP_MUL) ? prod[31:0] : prod[63:32];

  // One restoring-division step per cycle.  A zero divisor
  // naturally yields all-ones quotient and remainder = |dividend|.
  assign trial = {rem_q, opa_q[31]} - {1'b0, opb_q[31:0]};
  assign quo_n = {opa_q[30:0], ~trial[32]};
  assign rem_n = trial[32] ? {rem_q[30:0], opa_q[31]}
                           : trial[31:0];

  always_comb begin
    div_res = negq_q ? -quo_n : quo_n;
    unique case (mop_q)
      OP_REM, OP_REMU: div_res = negr_q ? -rem_n : rem_n;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mop_d   = mop_q;
    tag_d   = tag_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    vld_d   = 1'b0;
    src_d   = src_q;
    val_d   = val_q;
    if (alu_rb) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (rdy) begin
      unique case (state_q)
        S_IDLE: begin
          if (accept && is_m) begin
            mop_d = alu_opt;
            tag_d = alu_rob_idx;
            cnt_d = '0;
            if (is_div) begin
              state_d = S_DIV;
              opa_d   = {1'b0, abs_a};
              opb_d   = {1'b0, abs_b};
              rem_d   = '0;
              // divide-by-zero keeps the all-ones quotient
              negq_d  = (neg_a ^ neg_b) & (|alu_val2);
              negr_d  = neg_a;
            end else begin
              state_d = S_MUL;
              opa_d   = {neg_a, alu_val1};
              opb_d   = {neg_b, alu_val2};
            end
          end else if (accept) begin
            vld_d = 1'b1;
            src_d = alu_rob_idx;
            val_d = base_res;
          end
        end
        S_MUL: begin
          if (cnt_q == MUL_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            vld_d   = 1'b1;
            src_d   = tag_q;
            val_d   = mul_res;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_DIV: begin
          opa_d = {1'b0, quo_n};
          rem_d = rem_n;
          if (cnt_q == 5'd31) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            vld_d   = 1'b1;
            src_d   = tag_q;
            val_d   = div_res;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mop_q   <= '0;
      tag_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mop_q   <= mop_d;
      tag_q   <= tag_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign alu_busy = (state_q != S_IDLE);
`else
  assign alu_busy = 1'b0;

  always_comb begin
    vld_d = accept;
    src_d = src_q;
    val_d = val_q;
    if (accept) begin
      src_d = alu_rob_idx;
      val_d = base_res;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      src_q <= '0;
      val_q <= '0;
    end else begin
      vld_q <= vld_d;
      src_q <= src_d;
      val_q <= val_d;
    end
  end

  assign cdb_alu_valid = vld_q;
  assign cdb_alu_src   = src_q;
  assign cdb_alu_val   = val_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed vectors for alu_unit.
// Define ALU_MULDIV_EN to also cover the RV32M states.
module tb_alu_unit;
  import alu_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rdy;
  logic                  alu_rb;
  logic                  alu_ena;
  logic [INST_OPT_W-1:0] alu_opt;
  logic [31:0]           alu_val1;
  logic [31:0]           alu_val2;
  logic [31:0]           alu_imm;
  logic [ROB_IDX_W-1:0]  alu_rob_idx;
  logic                  alu_busy;
  logic                  cdb_alu_valid;
  logic [ROB_IDX_W-1:0]  cdb_alu_src;
  logic [31:0]           cdb_alu_val;

  int checks = 0;
  int errors = 0;

  alu_unit #(.MUL_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .alu_rb       (alu_rb),
    .alu_ena      (alu_ena),
    .alu_opt      (alu_opt),
    .alu_val1     (alu_val1),
    .alu_val2     (alu_val2),
    .alu_imm      (alu_imm),
    .alu_rob_idx  (alu_rob_idx),
    .alu_busy     (alu_busy),
    .cdb_alu_valid(cdb_alu_valid),
    .cdb_alu_src  (cdb_alu_src),
    .cdb_alu_val  (cdb_alu_val)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [INST_OPT_W-1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] im,
                        input logic [ROB_IDX_W-1:0] tg);
    alu_ena     = 1'b1;
    alu_opt     = op;
    alu_val1    = a;
    alu_val2    = b;
    alu_imm     = im;
    alu_rob_idx = tg;
  endtask

  // present one op for one edge; return at edge + 1
  task automatic drive(input logic [INST_OPT_W-1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] im,
                       input logic [ROB_IDX_W-1:0] tg);
    @(negedge clk);
    set_in(op, a, b, im, tg);
    @(posedge clk);
    #1;
    alu_ena = 1'b0;
  endtask

  task automatic alu1(input string tag,
                      input logic [INST_OPT_W-1:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] im,
                      input logic [31:0] exp);
    drive(op, a, b, im, 4'd6);
    chk({tag, "_vld"}, 32'(cdb_alu_valid), 32'd1);
    chk(tag, cdb_alu_val, exp);
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (n < 60 && !cdb_alu_valid) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic mcyc(input string tag,
                      input logic [INST_OPT_W-1:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [ROB_IDX_W-1:0] tg,
                      input int lat,
                      input logic [31:0] exp);
    int n;
    drive(op, a, b, 32'd0, tg);
    wait_vld(n);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_src"}, 32'(cdb_alu_src), 32'(tg));
    chk(tag, cdb_alu_val, exp);
  endtask

  initial begin
    int pulses;
    rst = 1'b0;
    rdy = 1'b1;
    alu_rb = 1'b0;
    alu_ena = 1'b0;
    alu_opt = '0;
    alu_val1 = '0;
    alu_val2 = '0;
    alu_imm = '0;
    alu_rob_idx = '0;
    #1;
    chk("rst_vld", 32'(cdb_alu_valid), 32'd0);
    chk("rst_src", 32'(cdb_alu_src), 32'd0);
    chk("rst_val", cdb_alu_val, 32'd0);
    chk("rst_busy", 32'(alu_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    drive(OP_ADD, 32'd5, 32'd7, 32'd99, 4'd3);
    chk("add_vld", 32'(cdb_alu_valid), 32'd1);
    chk("add_src", 32'(cdb_alu_src), 32'd3);
    chk("add_val", cdb_alu_val, 32'd12);
    @(posedge clk);
    #1;
    chk("add_drop", 32'(cdb_alu_valid), 32'd0);

    alu1("sub", OP_SUB, 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE);
    alu1("srai", OP_SRAI, 32'h8000_0000, 32'd0, 32'd4,
         32'hF800_0000);
    alu1("srl", OP_SRL, 32'h8000_0000, 32'd4, 32'd0,
         32'h0800_0000);
    alu1("sll33", OP_SLL, 32'd1, 32'd33, 32'd0, 32'd2);
    alu1("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
    alu1("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    alu1("slti", OP_SLTI, 32'd5, 32'd9, 32'hFFFF_FFFF, 32'd0);
    alu1("sltiu", OP_SLTIU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd1);
    alu1("xor", OP_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0,
         32'hFFFF_FFFF);
    alu1("and", OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'd0,
         32'h0F00_0F00);
    alu1("ori", OP_ORI, 32'hFF00_FF00, 32'hFFFF_FFFF, 32'h0000_000F,
         32'hFF00_FF0F);
    alu1("lui", OP_LUI, 32'hDEAD_BEEF, 32'd1, 32'h1234_5000,
         32'h1234_5000);
    alu1("auipc", OP_AUIPC, 32'h0000_1000, 32'd7, 32'h0000_2000,
         32'h0000_3000);
    alu1("beq", OP_BEQ, 32'd5, 32'd5, 32'd0, 32'd1);
    alu1("bne", OP_BNE, 32'd5, 32'd5, 32'd1, 32'd0);
    alu1("blt", OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
    alu1("bge", OP_BGE, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    alu1("bltu", OP_BLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1);
    alu1("bgeu", OP_BGEU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
    alu1("unk", 6'h3F, 32'd5, 32'd7, 32'd9, 32'd0);

    drive(OP_ADD, 32'd1, 32'd2, 32'd0, 4'd1);
    chk("b2b0_val", cdb_alu_val, 32'd3);
    drive(OP_ADD, 32'd3, 32'd4, 32'd0, 4'd2);
    chk("b2b1_vld", 32'(cdb_alu_valid), 32'd1);
    chk("b2b1_src", 32'(cdb_alu_src), 32'd2);
    chk("b2b1_val", cdb_alu_val, 32'd7);

    @(negedge clk);
    rdy = 1'b0;
    set_in(OP_ADD, 32'd1, 32'd1, 32'd0, 4'd4);
    @(posedge clk);
    #1;
    chk("stall_ign", 32'(cdb_alu_valid), 32'd0);
    @(negedge clk);
    rdy = 1'b1;
    alu_rb = 1'b1;
    @(posedge clk);
    #1;
    chk("rb_ign", 32'(cdb_alu_valid), 32'd0);
    alu_ena = 1'b0;
    alu_rb = 1'b0;

    drive(OP_ADD, 32'd8, 32'd8, 32'd0, 4'd7);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_vld", 32'(cdb_alu_valid), 32'd0);
    chk("arst_val", cdb_alu_val, 32'd0);
    chk("arst_src", 32'(cdb_alu_src), 32'd0);
    @(negedge clk);
    rst = 1'b1;

`ifdef ALU_MULDIV_EN
    drive(OP_MUL, 32'hFFFF_FFFF, 32'd3, 32'd0, 4'd9);
    chk("mul_busy0", 32'(alu_busy), 32'd1);
    chk("mul_vld0", 32'(cdb_alu_valid), 32'd0);
    @(negedge clk);
    set_in(OP_ADD, 32'd1, 32'd1, 32'd0, 4'd1);
    @(posedge clk);
    #1;
    alu_ena = 1'b0;
    chk("mul_busy1", 32'(alu_busy), 32'd1);
    chk("mul_vld1", 32'(cdb_alu_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("mul_vld", 32'(cdb_alu_valid), 32'd1);
    chk("mul_src", 32'(cdb_alu_src), 32'd9);
    chk("mul_val", cdb_alu_val, 32'hFFFF_FFFD);
    chk("mul_idle", 32'(alu_busy), 32'd0);
    @(posedge clk);
    #1;
    chk("mul_drop", 32'(cdb_alu_valid), 32'd0);

    mcyc("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 2,
         32'hFFFF_FFFE);
    mcyc("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 2,
         32'd0);
    mcyc("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 2,
         32'hFFFF_FFFF);
    mcyc("div0", OP_DIV, 32'd7, 32'd0, 4'd5, 32, 32'hFFFF_FFFF);
    mcyc("remu0", OP_REMU, 32'd7, 32'd0, 4'd5, 32, 32'd7);
    mcyc("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32,
         32'h8000_0000);
    mcyc("removf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32,
         32'd0);
    mcyc("divneg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'd1, 32,
         32'hFFFF_FFFD);
    mcyc("remneg", OP_REM, 32'hFFFF_FFF9, 32'd2, 4'd1, 32,
         32'hFFFF_FFFF);
    mcyc("divu", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 4'd3, 32,
         32'h0FFF_FFFF);

    drive(OP_DIVU, 32'd100, 32'd7, 32'd0, 4'd4);
    repeat (9) @(posedge clk);
    @(negedge clk);
    alu_rb = 1'b1;
    @(posedge clk);
    #1;
    alu_rb = 1'b0;
    chk("rb_busy", 32'(alu_busy), 32'd0);
    chk("rb_vld", 32'(cdb_alu_valid), 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (cdb_alu_valid) pulses++;
    end
    chk("rb_nobc", 32'(pulses), 32'd0);

    drive(OP_DIV, 32'd100, 32'd7, 32'd0, 4'd11);
    repeat (31) @(posedge clk);
    @(negedge clk);
    rdy = 1'b0;
    @(posedge clk);
    #1;
    chk("stl_vld", 32'(cdb_alu_valid), 32'd0);
    chk("stl_busy", 32'(alu_busy), 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("stl_hold", 32'(cdb_alu_valid), 32'd0);
    end
    @(negedge clk);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("stl_re", 32'(cdb_alu_valid), 32'd1);
    chk("stl_val", cdb_alu_val, 32'd14);
    chk("stl_src", 32'(cdb_alu_src), 32'd11);
    @(posedge clk);
    #1;
    chk("stl_once", 32'(cdb_alu_valid), 32'd0);

    drive(OP_MUL, 32'd6, 32'd7, 32'd0, 4'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_busy", 32'(alu_busy), 32'd0);
    chk("mrst_vld", 32'(cdb_alu_valid), 32'd0);
    chk("mrst_src", 32'(cdb_alu_src), 32'd0);
    chk("mrst_val", cdb_alu_val, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (cdb_alu_valid) pulses++;
    end
    chk("mrst_nobc", 32'(pulses), 32'd0);
`else
    drive(OP_MUL, 32'd6, 32'd7, 32'd0, 4'd9);
    chk("m_unk_vld", 32'(cdb_alu_valid), 32'd1);
    chk("m_unk_val", cdb_alu_val, 32'd0);
    chk("m_unk_src", 32'(cdb_alu_src), 32'd9);
    chk("m_unk_busy", 32'(alu_busy), 32'd0);
    drive(OP_DIV, 32'd7, 32'd0, 32'd0, 4'd2);
    chk("d_unk_val", cdb_alu_val, 32'd0);
    chk("d_unk_vld", 32'(cdb_alu_valid), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter MUL_STAGES, default 2, cycles a multiply spends in MUL state (legal 1..8).
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 rdy  input  1  global ready; low = stall.
REQ-005 alu_rb  input  1  rollback; discard all in-flight work.
REQ-006 alu_ena  input  1  issue strobe from reservation station, one op per cycle.
REQ-007 alu_opt  input  INST_OPT width  operation code.
REQ-008 alu_val1 / alu_val2 / alu_imm  input  32 each  operand A, operand B, immediate (val1 carries PC for AUIPC).
REQ-009 alu_rob_idx  input  ROB_IDX width  destination ROB tag.
REQ-010 alu_busy  output  1  high while a multi-cycle op occupies the unit; drives RS stall.
REQ-011 cdb_alu_valid  output  1  one-cycle result broadcast strobe.
REQ-012 cdb_alu_src / cdb_alu_val  output  ROB_IDX / 32  broadcast tag and result.

Function
REQ-013 Op accepted SHALL require alu_ena & rdy & !alu_rb & !alu_busy; otherwise inputs ignored.
REQ-014 Register-register ops SHALL use val2 as operand B; immediate forms SHALL use imm; LUI result = imm; AUIPC = val1 + imm.
REQ-015 Shifts SHALL use operand B[4:0]; SRA sign-extends; SLT/branch compares signed or unsigned per opcode.
REQ-016 Branch opcodes (BEQ..BGEU) SHALL return 32'd1 if taken, else 32'd0.
REQ-017 Unknown opcodes SHALL return 32'd0 with normal latency.
REQ-018 Single-cycle op accepted at edge N SHALL present cdb_alu_valid=1 with tag and result for exactly the cycle after edge N (latency 1).
REQ-019 FSM states IDLE, MUL, DIV; IDLE->MUL/DIV on accepted M-op; MUL->IDLE after MUL_STAGES cycles; DIV->IDLE after 32 cycles; broadcast pulses on the edge leaving MUL/DIV.
REQ-020 alu_busy SHALL be 1 in MUL/DIV, combinationally 0 in IDLE.
REQ-021 Operand tag SHALL be latched at acceptance and returned unchanged in cdb_alu_src.
REQ-022 Division by zero: DIV/DIVU quotient 32'hFFFFFFFF, REM/REMU remainder = dividend.
REQ-023 Signed overflow 32'h80000000 / -1: quotient 32'h80000000, remainder 0.
REQ-024 rdy low SHALL freeze FSM and counters and deassert cdb_alu_valid on that edge; a due broadcast re-emits on first rdy-high edge.
REQ-025 alu_rb SHALL (sync) force IDLE, clear counters, deassert cdb_alu_valid next edge; rb wins over same-cycle alu_ena and over a same-cycle completion.
REQ-026 At most one broadcast per cycle; no result ever dropped except by rb/reset.

Reset
REQ-027 rst low SHALL immediately set state IDLE, counters 0, cdb_alu_valid 0, cdb_alu_src 0, cdb_alu_val 0, alu_busy 0.
REQ-028 Reset mid-MUL/DIV SHALL discard the op with no broadcast after release.

Configuration
REQ-029 Macro ALU_MULDIV_EN defined: RV32M ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) implemented via MUL/DIV states.
REQ-030 ALU_MULDIV_EN undefined: MUL/DIV states and datapath absent, M opcodes treated as unknown (REQ-017), alu_busy tied 0.

Verification
REQ-031 ADD val1=5, val2=7, tag 3 -> next cycle valid=1, src=3, val=12; following cycle valid=0.
REQ-032 SRAI val1=32'h80000000, imm=4 -> val=32'hF8000000; BLTU val1=1, val2=32'hFFFFFFFF -> val=1.
REQ-033 (MULDIV_EN, MUL_STAGES=2) MUL 32'hFFFFFFFF x 3, tag 9 -> busy 2 cycles, then val=32'hFFFFFFFD, src=9; DIV 7/0 -> 32'hFFFFFFFF after 32 cycles; REM 80000000/-1 -> 0.
REQ-034 DIVU issued, alu_rb at cycle 10 -> busy drops next cycle, no broadcast; ADD issued with rb same cycle ignored.
REQ-035 rdy low cycle DIV completes -> no pulse; rdy high -> single pulse, correct quotient; async rst mid-MUL -> outputs zero immediately, no later broadcast.
